mcp3008_scan_scheduler: RTL

- Sequences every SPI conversion frame to the MCP3008 8-channel 10-bit ADC.
- Arbitrates between a free-running round-robin background scan of enabled channels and on-demand single-channel requests from the control logic.
- Sits between the ADC pins (AD_CLK/CS/DIN/DOUT) and the motor-control datapath, which reads scan results from a per-channel table.
- Replaces ad-hoc frame generation inside the control loop.

---
 rtl/mcp3008_scan_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mcp3008_scan_scheduler.sv
// MCP3008 SPI frame sequencer: round-robin background scan of CH_MASK channels plus on-demand requests.
// Build option ADC_SCAN_IIR_EN: scan table entries are low-pass filtered (old + (new - old)/4).
module mcp3008_scan_scheduler #(
    parameter int         CLK_DIV = 25,
    parameter int         CS_IDLE = 50,
    parameter logic [7:0] CH_MASK = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        req_valid,
    input  logic [2:0]  req_ch,
    output logic        req_ready,
    output logic        AD_CLK,
    output logic        CS,
    output logic        DIN,
    input  logic        DOUT,
    output logic        result_valid,
    output logic [2:0]  result_ch,
    output logic [9:0]  result_data,
    output logic        result_src,
    output logic [79:0] ch_data
);
    // state   | meaning
    // S_IDLE  | CS high, choose next frame (request vs scan)
    // S_SETUP | CS low, SCK low for CLK_DIV cycles
    // S_SHIFT | 17 SCK periods: command out, 10 result bits in
    // S_HOLD  | CS high, result pulse, CS_IDLE cycle gap
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    localparam int TMR_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr;
    logic             tmr_tc;
    logic             sck;
    logic [4:0]       redge;
    logic [4:0]       cmd_sr;
    logic [9:0]       rx;
    logic [2:0]       cur_ch, scan_ptr, scan_next, scan_idx, frame_ch;
    logic             scan_hit;
    logic             cur_src, last_od;
    logic             scan_due, force_scan;
    logic             start_scan, start_od, start;
    logic             sck_rise, sck_fall, shift_done;
    logic [9:0]       tbl_new;

    assign tmr_tc     = (tmr == '0);
    assign scan_due   = scan_en && (CH_MASK != 8'h00);
    // After an on-demand frame a due scan frame goes first so requests cannot starve the scan.
    assign force_scan = last_od && scan_due;
    assign start      = start_scan || start_od;
    assign frame_ch   = start_od ? req_ch : scan_next;

    assign sck_rise   = tmr_tc && ((state_q == S_SETUP) ||
                                   (state_q == S_SHIFT && !sck && redge != 5'd17));
    assign sck_fall   = tmr_tc && (state_q == S_SHIFT) && sck;
    assign shift_done = (state_q == S_SHIFT) && !sck && (redge == 5'd17);

    assign AD_CLK = sck;
    assign CS     = !((state_q == S_SETUP) || (state_q == S_SHIFT));
    assign DIN    = cmd_sr[4];

    always_comb begin
        scan_next = scan_ptr;
        scan_idx  = scan_ptr;
        scan_hit  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            scan_idx = scan_ptr + 3'(i);
            if (!scan_hit && CH_MASK[scan_idx]) begin
                scan_next = scan_idx;
                scan_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        start_scan = 1'b0;
        start_od   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = !force_scan && !rst;
                if (force_scan)     start_scan = 1'b1;
                else if (req_valid) start_od   = 1'b1;
                else if (scan_due)  start_scan = 1'b1;
                if (start_scan || start_od) state_d = S_SETUP;
            end
            S_SETUP: if (tmr_tc)     state_d = S_SHIFT;
            S_SHIFT: if (shift_done) state_d = S_HOLD;
            S_HOLD:  if (tmr_tc)     state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr          <= '0;
            sck          <= 1'b0;
            redge        <= '0;
            cmd_sr       <= '0;
            rx           <= '0;
            cur_ch       <= '0;
            cur_src      <= 1'b0;
            last_od      <= 1'b0;
            scan_ptr     <= 3'd7;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
            result_src   <= 1'b0;
        end else begin
            if (start)
                tmr <= TMR_W'(CLK_DIV - 1);
            else if (shift_done)
                tmr <= TMR_W'(CS_IDLE - 1);
            else if (tmr_tc) begin
                if (state_q == S_SETUP || state_q == S_SHIFT) tmr <= TMR_W'(CLK_DIV - 1);
            end else
                tmr <= tmr - TMR_W'(1);

            if (start) begin
                cur_ch  <= frame_ch;
                cur_src <= start_od;
                last_od <= start_od;
                cmd_sr  <= {2'b11, frame_ch};
                rx      <= '0;
                redge   <= '0;
                if (start_scan) scan_ptr <= scan_next;
            end else begin
                if (sck_fall) cmd_sr <= {cmd_sr[3:0], 1'b0};
                if (sck_rise) redge <= redge + 5'd1;
                if (sck_rise && redge >= 5'd7) rx <= {rx[8:0], DOUT};
            end

            if (sck_rise)      sck <= 1'b1;
            else if (sck_fall) sck <= 1'b0;

            result_valid <= shift_done;
            if (shift_done) begin
                result_ch   <= cur_ch;
                result_data <= rx;
                result_src  <= cur_src;
            end
        end
    end

`ifdef ADC_SCAN_IIR_EN
    logic [7:0]         ch_seen;
    logic [9:0]         tbl_old;
    logic signed [10:0] iir_diff, iir_sum;

    always_comb begin
        tbl_old  = ch_data[int'(result_ch) * 10 +: 10];
        iir_diff = $signed({1'b0, result_data}) - $signed({1'b0, tbl_old});
        iir_sum  = $signed({1'b0, tbl_old}) + (iir_diff >>> 2);
        tbl_new  = ch_seen[result_ch] ? iir_sum[9:0] : result_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              ch_seen            <= '0;
        else if (result_valid && !result_src) ch_seen[result_ch] <= 1'b1;
    end
`else
    assign tbl_new = result_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ch_data <= '0;
        else if (result_valid && !result_src)
            ch_data[int'(result_ch) * 10 +: 10] <= tbl_new;
    end
endmodule
